dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
Round-robin arbiter and sequencer for one shared W-bit register bank, built from master-slave DFF bits, that N requesters write into.
- Grants the bank to one requester at a time.
- Captures the granted requester's data word into the bank.
- Enforces a bounded hold time and a dead turnaround cycle between owners.
- Sits between requester logic and the shared storage word; outQ is the bank output.

Parameters:
N, 4, number of requesters (2..8)
W, 8, register bank width in bits
MAX_HOLD, 4, max consecutive owned cycles while another request is pending; 0 = unlimited
OW, 2, owner index width (clog2(N)), kept consistent with N by the instantiating code

Ports:
inClk  input  1  single clock, all state updates on rising edge
inRst  input  1  synchronous, active-high reset
inReq  input  N  per-requester request, level; held until done
inData  input  N*W  packed write data, slice i = inData[i*W +: W]
outGnt  output  N  one-hot grant, registered; all-zero when no owner
outOwner  output  OW  index of current/last owner
outQ  output  W  register bank contents
outValid  output  1  1-cycle pulse: outQ was loaded at this edge

Behaviour:
- Reset (inRst=1 at an edge):
  - outGnt=0, outOwner=0, outQ=0, outValid=0.
  - State=S_IDLE, priority pointer ptr=0, holdCnt=0.
  - Reset overrides all other activity, including mid-ownership; no capture happens on a reset edge.
- FSM states: S_IDLE, S_OWNED, S_GAP.
- S_IDLE:
  - If inReq != 0, pick the first set bit searching ptr, ptr+1, ... mod N.
  - Next edge: outGnt=onehot(i), outOwner=i, holdCnt=0, state S_OWNED.
  - Latency: inReq sampled at edge k -> grant visible after edge k.
  - If no request, stay in S_IDLE with outGnt=0.
- S_OWNED, owner i:
  - If inReq[i]=1 at edge: outQ<=inData slice i, outValid<=1, holdCnt<=holdCnt+1.
  - Release when either:
    - inReq[i]=0 at edge (no capture on that edge), or
    - MAX_HOLD!=0 and holdCnt==MAX_HOLD-1 and a capture occurs and some other inReq[j]=1 (j!=i). That final capture still happens.
  - On release: outGnt<=0, ptr<=(i+1) mod N, state S_GAP.
  - With MAX_HOLD=0, or no competing request, ownership continues indefinitely; holdCnt saturates at MAX_HOLD-1.
- S_GAP:
  - One dead cycle: outGnt=0, no capture.
  - Then unconditionally S_IDLE.
  - Minimum turnaround release -> next grant = 2 edges.
- outQ holds its value whenever no capture occurs. outValid=0 on every non-capture edge.
- outOwner keeps the last owner value through S_GAP/S_IDLE.
- inData is ignored for non-owners. Requests that arrive or drop while another requester owns the bank have no effect until arbitration.
- A requester whose inReq drops in the same cycle its grant appears is released next edge with no capture. ptr still advances.
- ptr wrap: N-1 -> 0.

Decomposition:
- Shared include dff_arb_defs.vh holds:
  - state encodings S_IDLE=2'd0, S_OWNED=2'd1, S_GAP=2'd2;
  - default N/W/MAX_HOLD values.
- Sub-module rr_pick (combinational): inputs req[N], ptr[OW]; outputs found, idx[OW]. It is reused by other arbiters.
- The W-bit bank is a plain registered word inside dff_bank_arbiter.

Test Plan:
All scenarios use N=4, W=8, MAX_HOLD=4.
1. Reset then idle: inRst=1 for 2 edges, inReq=0 -> outGnt=0, outQ=8'h00, outValid=0, outOwner=0 throughout.
2. Single requester: inReq=4'b0100, slice2=8'hA5 for 3 owned edges, then drop.
   - Grant 4'b0100 one edge after request.
   - outQ=8'hA5 with 3 outValid pulses.
   - Release, one gap cycle, next ptr=3.
3. Round-robin contention: inReq=4'b1011 held, ptr=0.
   - Owner order 0,1,3,0.
   - Each owner gets exactly 4 captures.
   - Exactly 1 gap cycle between owners; outGnt never has more than one bit set.
4. Unlimited hold: MAX_HOLD=0, inReq=4'b0011 for 20 edges -> requester 0 keeps the grant all 20 edges; requester 1 is never granted.
5. Mid-ownership reset: owner 1 after 2 captures (outQ=8'h3C), assert inRst one edge -> next edge outGnt=0, outQ=8'h00, ptr=0; arbitration restarts from requester 0.
6. Drop on grant: inReq[2] pulses 1 cycle -> grant 4'b0100 appears, releases next edge with no outValid pulse; outQ unchanged.

Source files
------------

// File: rtl/dff_bank_arbiter_pkg.sv
// rtl/dff_bank_arbiter_pkg.sv - shared state encodings and default sizes for the bank arbiter
package dff_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWNED = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;
  localparam int DEF_OW       = 2;

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// rtl/dff_bank_arbiter_if.sv - requester/bank bus between requester logic and the arbiter
interface dff_bank_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int OW = 2
);

  logic [N-1:0]   inReq;
  logic [N*W-1:0] inData;
  logic [N-1:0]   outGnt;
  logic [OW-1:0]  outOwner;
  logic [W-1:0]   outQ;
  logic           outValid;

  modport master (
    output inReq, inData,
    input  outGnt, outOwner, outQ, outValid
  );

  modport slave (
    input  inReq, inData,
    output outGnt, outOwner, outQ, outValid
  );

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// rtl/dff_bank_arbiter_rr_pick.sv - combinational round-robin picker, first set request at or after ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [OW-1:0] ptr_i,
  output logic          found_o,
  output logic [OW-1:0] idx_o
);

  logic [OW-1:0] cand;

  // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = OW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin owner sequencing and capture into one shared W-bit bank
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int OW       = DEF_OW
) (
  input logic              inClk,
  input logic              inRst,
  dff_bank_arbiter_if.slave bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  state_e        state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [W-1:0]  q_q, q_d;
  logic          valid_q, valid_d;

  logic          pick_found;
  logic [OW-1:0] pick_idx;
  logic          owner_req;
  logic          others_req;

  rr_pick #(.N(N), .OW(OW)) u_pick (
    .req_i   (bus.inReq),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign owner_req  = bus.inReq[owner_q];
  assign others_req = |(bus.inReq & ~gnt_q);

  // Next-state: arbitration in idle, capture and release decisions while owned, one dead gap cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    q_d     = q_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d = S_OWNED;
          owner_d = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          hold_d  = '0;
        end
      end
      S_OWNED: begin
        if (owner_req) begin
          q_d     = bus.inData[int'(owner_q) * W +: W];
          valid_d = 1'b1;
          if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_req) begin
            // Hold budget used up with a competitor waiting: last capture, then hand over.
            state_d = S_GAP;
            gnt_d   = '0;
            ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + HW'(1);
          end
        end else begin
          state_d = S_GAP;
          gnt_d   = '0;
          ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
        end
      end
      S_GAP: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and bank registers; reset wins over any capture or grant on the same edge.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign bus.outGnt   = gnt_q;
  assign bus.outOwner = owner_q;
  assign bus.outQ     = q_q;
  assign bus.outValid = valid_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - scoreboard bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int OW = 2;

  logic inClk = 1'b0;
  logic inRst = 1'b1;
  logic mon_en = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [OW+W-1:0] exp_q[$];
  logic [OW+W-1:0] exp2_q[$];

  dff_bank_arbiter_if #(.N(N), .W(W), .OW(OW)) bus ();
  dff_bank_arbiter_if #(.N(N), .W(W), .OW(OW)) bus2 ();

  dff_bank_arbiter #(.N(N), .W(W), .MAX_HOLD(4), .OW(OW)) dut (
    .inClk (inClk),
    .inRst (inRst),
    .bus   (bus)
  );

  dff_bank_arbiter #(.N(N), .W(W), .MAX_HOLD(0), .OW(OW)) dut_unl (
    .inClk (inClk),
    .inRst (inRst),
    .bus   (bus2)
  );

  always #5 inClk = ~inClk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge inClk);
    @(negedge inClk);
  endtask

  logic [OW+W-1:0] ent;
  logic [OW+W-1:0] ent2;

  always @(negedge inClk) begin
    if (mon_en) begin
      check_val("gnt_onehot", 32'($countones(bus.outGnt) <= 1), 32'd1);
      if (bus.outValid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_valid", 32'(bus.outQ), 32'hFFFF_FFFF);
        end else begin
          ent = exp_q.pop_front();
          check_val("capture", 32'({bus.outOwner, bus.outQ}), 32'(ent));
        end
      end
      if (bus2.outValid) begin
        if (exp2_q.size() == 0) begin
          check_val("unexpected_valid2", 32'(bus2.outQ), 32'hFFFF_FFFF);
        end else begin
          ent2 = exp2_q.pop_front();
          check_val("capture2", 32'({bus2.outOwner, bus2.outQ}), 32'(ent2));
        end
      end
    end
  end

  int owners[4] = '{0, 1, 3, 0};
  logic [N-1:0] oh;

  initial begin
    bus.inReq   = '0;
    bus.inData  = '0;
    bus2.inReq  = '0;
    bus2.inData = '0;

    // reset then idle
    inRst = 1'b1;
    tick();
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_val("rst_gnt", 32'(bus.outGnt), 32'd0);
      check_val("rst_q", 32'(bus.outQ), 32'd0);
      check_val("rst_valid", 32'(bus.outValid), 32'd0);
      check_val("rst_owner", 32'(bus.outOwner), 32'd0);
      if (i == 0) tick();
    end
    inRst = 1'b0;
    tick();
    tick();
    check_val("idle_gnt", 32'(bus.outGnt), 32'd0);
    check_val("idle_q", 32'(bus.outQ), 32'd0);

    // single requester 2
    bus.inReq = 4'b0100;
    bus.inData = $urandom;
    bus.inData[2*W +: W] = 8'hA5;
    tick();
    check_val("single_grant", 32'(bus.outGnt), 32'h4);
    check_val("single_owner", 32'(bus.outOwner), 32'd2);
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back({2'd2, 8'hA5});
      tick();
      check_val("single_hold", 32'(bus.outGnt), 32'h4);
    end
    bus.inReq = '0;
    tick();
    check_val("single_rel_gnt", 32'(bus.outGnt), 32'd0);
    check_val("single_rel_valid", 32'(bus.outValid), 32'd0);
    check_val("single_q", 32'(bus.outQ), 32'hA5);
    bus.inReq = 4'b1001;
    tick();
    check_val("gap_gnt", 32'(bus.outGnt), 32'd0);
    tick();
    check_val("ptr3_grant", 32'(bus.outGnt), 32'h8);
    check_val("ptr3_owner", 32'(bus.outOwner), 32'd3);
    bus.inReq = '0;
    tick();
    check_val("ptr3_rel", 32'(bus.outGnt), 32'd0);
    tick();

    // drop on grant, ptr now 0
    bus.inReq = 4'b0100;
    bus.inData = $urandom;
    tick();
    check_val("dog_grant", 32'(bus.outGnt), 32'h4);
    bus.inReq = '0;
    tick();
    check_val("dog_rel", 32'(bus.outGnt), 32'd0);
    check_val("dog_valid", 32'(bus.outValid), 32'd0);
    check_val("dog_q", 32'(bus.outQ), 32'hA5);
    check_val("dog_owner", 32'(bus.outOwner), 32'd2);
    tick();

    // mid-ownership reset, ptr now 3
    bus.inReq = 4'b0010;
    bus.inData = $urandom;
    bus.inData[1*W +: W] = 8'h3C;
    tick();
    check_val("mr_grant", 32'(bus.outGnt), 32'h2);
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back({2'd1, 8'h3C});
      tick();
    end
    check_val("mr_q", 32'(bus.outQ), 32'h3C);
    inRst = 1'b1;
    tick();
    check_val("mr_gnt", 32'(bus.outGnt), 32'd0);
    check_val("mr_q0", 32'(bus.outQ), 32'd0);
    check_val("mr_owner", 32'(bus.outOwner), 32'd0);
    check_val("mr_valid", 32'(bus.outValid), 32'd0);
    inRst = 1'b0;

    // round-robin contention from ptr 0
    bus.inReq = 4'b1011;
    for (int p = 0; p < 4; p++) begin
      oh = 4'b0001 << owners[p];
      bus.inData = $urandom;
      tick();
      check_val("rr_grant", 32'(bus.outGnt), 32'(oh));
      check_val("rr_owner", 32'(bus.outOwner), 32'(owners[p]));
      for (int c = 0; c < 4; c++) begin
        bus.inData = $urandom;
        exp_q.push_back({2'(owners[p]), bus.inData[owners[p]*W +: W]});
        tick();
        if (c < 3) check_val("rr_hold", 32'(bus.outGnt), 32'(oh));
        else check_val("rr_release", 32'(bus.outGnt), 32'd0);
      end
      tick();
      check_val("rr_gap_gnt", 32'(bus.outGnt), 32'd0);
      check_val("rr_gap_valid", 32'(bus.outValid), 32'd0);
    end
    bus.inReq = '0;
    tick();
    check_val("rr_idle", 32'(bus.outGnt), 32'd0);

    // unlimited hold on the MAX_HOLD=0 instance
    bus2.inReq = 4'b0011;
    for (int e = 1; e <= 20; e++) begin
      bus2.inData = $urandom;
      if (e >= 2) exp2_q.push_back({2'd0, bus2.inData[W-1:0]});
      tick();
      check_val("unl_grant", 32'(bus2.outGnt), 32'h1);
    end
    bus2.inReq = '0;
    tick();
    check_val("unl_rel", 32'(bus2.outGnt), 32'd0);
    tick();

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    check_val("sb2_drained", 32'(exp2_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
